// File: rtl/t_meas_ctrl_if.sv
// Config/result bus of the measurement sequencer: start/abort/window request in,
// captured edge count out on a valid/ready handshake.
interface t_meas_ctrl_if #(
  parameter int CNT_W = 12,
  parameter int WIN_W = 16
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] res_data;
  logic             res_sat;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  modport master (
    output start, abort, win_len, res_ready,
    input  res_data, res_sat, res_valid, busy
  );

  modport slave (
    input  start, abort, win_len, res_ready,
    output res_data, res_sat, res_valid, busy
  );
endinterface

// File: rtl/t_meas_ctrl.sv
// Measurement-window sequencer: counts rising edges of sig_in via t_counter over a
// programmable window, saturating at all-ones, and hands the result out on valid/ready.
module t_meas_ctrl #(
  parameter int CNT_W = 12,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  t_meas_ctrl_if.slave     bus,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             cnt_enb,
  output logic             cnt_rise
);

  typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, HOLD} state_t;

  state_t           state, state_nxt;
  logic             sig_q1, sig_q2;
  logic             rise_det;
  logic             cnt_full;
  logic             start_ok;
  logic             sat;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] res_data_q;
  logic             res_sat_q;
  logic             res_valid;

  assign rise_det = sig_q1 & ~sig_q2;
  assign cnt_full = &cnt_in;
  // A zero-length window is a no-op request; abort always beats start.
  assign start_ok = bus.start & ~bus.abort & (bus.win_len != '0);

  assign bus.res_data  = res_data_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.res_valid = res_valid;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q1 <= 1'b0;
      sig_q2 <= 1'b0;
    end else begin
      sig_q1 <= sig_in;
      sig_q2 <= sig_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_enb   = 1'b0;
    cnt_rise  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = COUNT;
      end
      COUNT: begin
        cnt_enb  = 1'b1;
        // Drop edges once the counter is full so it never wraps.
        cnt_rise = rise_det & ~cnt_full;
        if (win_cnt <= WIN_W'(1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        cnt_enb   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  // Window counter: loaded with L on accept, stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (state == IDLE) begin
      if (start_ok) win_cnt <= bus.win_len;
    end else if (state == COUNT && win_cnt != '0) begin
      win_cnt <= win_cnt - WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (bus.abort || state == IDLE) begin
      sat <= 1'b0;
    end else if (state == COUNT && rise_det && cnt_full) begin
      sat <= 1'b1;
    end
  end

  // Result registers keep their value after the handshake; an abort in CAPTURE yields nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
    end else if (state == CAPTURE && !bus.abort) begin
      res_data_q <= cnt_in;
      res_sat_q  <= sat;
    end
  end

endmodule
